debug_dump_sequencer: RTL

Sequences the end-of-run state dump of the MIPS debug unit onto the shared UART transmitter. On a start pulse it snapshots PC and cycle count, then walks the register file and data memory, feeding one byte at a time to the UART TX and waiting for each byte to finish. It sits between the debug unit FSM (which issues start and consumes end_send_data) and uart TX, and is the only requester of TX during a dump.

---
 rtl/debug_pkg.sv | 37 +++
 rtl/dbg_word_shifter.sv | 36 +++
 rtl/debug_dump_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared encodings and byte-count constants for the debug dump sequencer.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } dump_state_t;

  typedef enum logic [2:0] {
    SEC_PC,
    SEC_CYC,
    SEC_REG,
    SEC_MEM,
    SEC_CSUM
  } dump_sec_t;

  localparam int N_BYTES_PC        = 4;
  localparam int N_BYTES_CYCLES    = 1;
  localparam int N_BYTES_WORD      = 4;
  localparam int N_BYTES_CSUM      = 1;
  localparam int N_DUMP_WORDS      = 32;
  localparam int N_BYTES_DUMP      = N_BYTES_PC + N_BYTES_CYCLES + 2 * N_DUMP_WORDS * N_BYTES_WORD;
  localparam int N_BYTES_DUMP_CSUM = N_BYTES_DUMP + N_BYTES_CSUM;

  function automatic logic [2:0] sec_nbytes(input dump_sec_t sec);
    case (sec)
      SEC_PC:   return 3'(N_BYTES_PC);
      SEC_CYC:  return 3'(N_BYTES_CYCLES);
      SEC_CSUM: return 3'(N_BYTES_CSUM);
      default:  return 3'(N_BYTES_WORD);
    endcase
  endfunction

endpackage

// File: rtl/dbg_word_shifter.sv
// Holds the word being sent; presents its low byte and shifts one byte per send.
// last is a terminal-count compare on the remaining-byte down-counter.
module dbg_word_shifter #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [NB_DATA-1:0] word,
  input  logic [2:0]         nbytes,
  output logic [NB_BYTE-1:0] data_byte,
  output logic               last
);

  logic [NB_DATA-1:0] word_q;
  logic [2:0]         cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      word_q <= word;
      cnt_q  <= nbytes;
    end else if (shift) begin
      word_q <= word_q >> NB_BYTE;
      cnt_q  <= cnt_q - 3'd1;
    end
  end

  assign data_byte = word_q[NB_BYTE-1:0];
  assign last      = (cnt_q == 3'd1);

endmodule

// File: rtl/debug_dump_sequencer.sv
// Streams PC, cycle count, register file and data memory bytes onto the UART TX.
// Build option DEBUG_DUMP_CHECKSUM_EN appends an XOR checksum byte after MEM[31].
//
// state | meaning
// IDLE  | waiting for start_i, snapshots PC and cycles on start
// FETCH | load the next item word (snapshot, register or memory)
// SEND  | tx_start_o pulse with the current byte
// WAIT  | waiting for tx_done_i, then next byte or next item
// DONE  | end_send_data_o pulse
module debug_dump_sequencer
  import debug_pkg::*;
#(
  parameter int NB_DATA     = 32,
  parameter int NB_BYTE     = 8,
  parameter int N_REGISTER  = 32,
  parameter int N_MEM_WORDS = 32,
  parameter int NB_CYCLES   = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [NB_DATA-1:0]   pc_i,
  input  logic [NB_CYCLES-1:0] cycles_i,
  output logic [4:0]           reg_addr_o,
  input  logic [NB_DATA-1:0]   reg_data_i,
  output logic [4:0]           mem_addr_o,
  input  logic [NB_DATA-1:0]   mem_data_i,
  output logic [NB_BYTE-1:0]   tx_data_o,
  output logic                 tx_start_o,
  input  logic                 tx_done_i,
  output logic                 busy_o,
  output logic                 end_send_data_o
);

  localparam logic [4:0] LAST_REG = 5'(N_REGISTER - 1);
  localparam logic [4:0] LAST_MEM = 5'(N_MEM_WORDS - 1);

  dump_state_t state_q, state_d;
  dump_sec_t   sec_q, sec_d;
  logic [4:0]  idx_q, idx_d;

  logic [NB_DATA-1:0]   pc_snap_q;
  logic [NB_CYCLES-1:0] cyc_snap_q;
  logic                 capture, load, shift, last_byte;
  logic [NB_DATA-1:0]   load_word, csum_word;
  logic [NB_BYTE-1:0]   tx_byte;

`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
  logic [NB_BYTE-1:0] csum_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)                csum_q <= '0;
    else if (capture)           csum_q <= '0;
    else if (state_q == ST_SEND) csum_q <= csum_q ^ tx_byte;
  end

  assign csum_word = NB_DATA'(csum_q);
`else
  localparam bit CSUM_EN = 1'b0;
  assign csum_word = '0;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      sec_q      <= SEC_PC;
      idx_q      <= '0;
      pc_snap_q  <= '0;
      cyc_snap_q <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      idx_q   <= idx_d;
      if (capture) begin
        pc_snap_q  <= pc_i;
        cyc_snap_q <= cycles_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    idx_d   = idx_q;
    capture = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          capture = 1'b1;
          sec_d   = SEC_PC;
          idx_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        load    = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_done_i) begin
          if (!last_byte) begin
            shift   = 1'b1;
            state_d = ST_SEND;
          end else begin
            state_d = ST_FETCH;
            idx_d   = '0;
            case (sec_q)
              SEC_PC:  sec_d = SEC_CYC;
              SEC_CYC: sec_d = SEC_REG;
              SEC_REG: begin
                if (idx_q == LAST_REG) sec_d = SEC_MEM;
                else                   idx_d = idx_q + 5'd1;
              end
              SEC_MEM: begin
                if (idx_q != LAST_MEM) begin
                  idx_d = idx_q + 5'd1;
                end else if (CSUM_EN) begin
                  sec_d = SEC_CSUM;
                end else begin
                  sec_d   = SEC_PC;
                  state_d = ST_DONE;
                end
              end
              default: begin
                sec_d   = SEC_PC;
                state_d = ST_DONE;
              end
            endcase
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (sec_q)
      SEC_PC:   load_word = pc_snap_q;
      SEC_CYC:  load_word = NB_DATA'(cyc_snap_q);
      SEC_REG:  load_word = reg_data_i;
      SEC_MEM:  load_word = mem_data_i;
      SEC_CSUM: load_word = csum_word;
      default:  load_word = '0;
    endcase
  end

  dbg_word_shifter #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_shifter (
    .clk       (clock_i),
    .rst       (reset_i),
    .load      (load),
    .shift     (shift),
    .word      (load_word),
    .nbytes    (sec_nbytes(sec_q)),
    .data_byte (tx_byte),
    .last      (last_byte)
  );

  // Addresses follow the next-cycle index so the one-cycle read latency lands in FETCH.
  assign reg_addr_o      = (sec_d == SEC_REG) ? idx_d : '0;
  assign mem_addr_o      = (sec_d == SEC_MEM) ? idx_d : '0;
  assign tx_data_o       = tx_byte;
  assign tx_start_o      = (state_q == ST_SEND);
  assign end_send_data_o = (state_q == ST_DONE);
  assign busy_o          = (state_q != ST_IDLE);

endmodule
